wm_panel_ctrl: RTL and testbench
================================

# wm_panel_ctrl

Front-panel controller that sits directly upstream of the washing-machine controller FSM and drives its `power`, `start`, `doorclosed`, `soap` and `program_selection` inputs. It debounces the raw panel switches and sensors, and cycles the program selection with a single "next" button. It issues a clean start request and locks the selection while a program runs, using the controller's `lockDoor` and `program_done` outputs as feedback.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a raw input must differ from its filtered value before the filtered value flips (range 2..255).
- `START_TIMEOUT`, default 8: cycles `start` is held waiting for `busy` before the request is abandoned (range 1..255).
- `clk` input 1: system clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `power_sw_raw` input 1: raw power switch.
- `btn_next_raw` input 1: raw program-select button (1 = pressed).
- `btn_start_raw` input 1: raw start button.
- `door_raw` input 1: raw door sensor (1 = closed).
- `soap_raw` input 1: raw soap sensor (1 = present).
- `busy` input 1: controller `lockDoor` feedback.
- `program_done` input 1: controller completion flag.
- `power` output 1: debounced power.
- `doorclosed` output 1: debounced door.
- `soap` output 1: debounced soap.
- `program_selection` output 3: 0 cold, 1 hot, 2 rinse+dry, 3 dry only, 4 warm.
- `start` output 1: start request to the controller.
- `done_led` output 1: program-finished indicator.
- `start_fail` output 1: one-cycle pulse when a start request times out.

## Operation
- Five inputs share one debouncer scheme: a per-input counter of width ceil(log2(DEBOUNCE_CYCLES)), plus a filtered bit.
  - Raw == filtered: the counter clears.
  - Raw != filtered: the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and raw still differs, the filtered bit flips and the counter clears.
- Rising-edge detect on filtered next and start uses a registered copy of each filtered bit.
- State machine:
  - **OFF**
    - `power`=0.
    - `program_selection` forced to 0.
    - Go to READY when `power`=1.
  - **READY**
    - Next edge: `program_selection` increments, with 4 wrapping to 0.
    - Start edge with `doorclosed`=1: go to ARMED and clear the timeout counter.
    - Start edge with `doorclosed`=0: ignored.
  - **ARMED**
    - `start`=1 and the timeout counter increments.
    - `busy`=1: go to RUNNING.
    - Counter reaches START_TIMEOUT with `busy`=0: go to READY and pulse `start_fail`.
    - Next edges are ignored.
  - **RUNNING**
    - `start`=0 and the selection is frozen.
    - Next and start edges are ignored.
    - `program_done`=1: go to DONE.
  - **DONE**
    - `done_led`=1.
    - Filtered door falling (door opened) or a next edge: go to READY.
    - A next edge that exits DONE does not also increment the selection.
- `power` falling in any state: go to OFF on the next edge.
  - `start`, `done_led` and `start_fail` deassert.
  - `program_selection` becomes 0.
- Priority on the same cycle: power off > `busy` > timeout > button edges.
- `doorclosed`, `soap` and `power` are the filtered bits passed straight through, in every state.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State OFF; all counters 0; all filtered bits 0.
  - All outputs 0: `power`, `doorclosed`, `soap`, `program_selection`=0, `start`, `done_led`, `start_fail`.
- Reset deassertion mid-operation restarts from OFF. Raw inputs held high re-filter after DEBOUNCE_CYCLES edges.
- Debounce latency: the filtered output changes on the DEBOUNCE_CYCLES-th rising edge at which the changed raw value is sampled. A glitch shorter than that produces no change.
- Button action latency: one further edge after the filtered rise.
  - Raw start press to `start`=1: DEBOUNCE_CYCLES+1 edges.
  - Raw next press to selection change: DEBOUNCE_CYCLES+1 edges.
- `start` is high for at least 1 and at most START_TIMEOUT cycles. It drops on the edge after `busy` is sampled high.
- `start_fail` is high for exactly one cycle, coincident with the ARMED to READY transition.
- Holding a button produces exactly one action. A new action needs release, then re-press, each filtered.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- **Reset:** `rst_n`=0 mid-ARMED -> all outputs 0 immediately. After release with all raw inputs 0, outputs remain 0.
- **Debounce:** `btn_next_raw` pulses high for 3 cycles (DEBOUNCE_CYCLES=4) -> selection unchanged. Then held for 4 cycles -> selection 0→1 exactly 5 edges after the press. Five more clean presses -> selection reads 2,3,4,0,1.
- **Normal start:** power on, door closed, selection 3, start pressed -> `start`=1. `busy` raised 3 cycles later -> `start` falls the next edge and state is RUNNING. Next presses now leave selection at 3. `program_done`=1 -> `done_led`=1. Door opened -> `done_led`=0 after debounce.
- **Start timeout:** door closed, start pressed, `busy` held 0 -> `start` high for exactly 8 cycles, then a one-cycle `start_fail` pulse and return to READY.
- **Door open:** start pressed with `door_raw`=0 -> `start` never asserts.
- **Power loss:** power switch dropped while RUNNING -> OFF after debounce, `program_selection`=0, `start`=0, `done_led`=0.

Source files
------------

// File: rtl/wm_panel_ctrl.sv
// Washing-machine front-panel controller: debounces the panel switches and sensors,
// cycles the program selection and hands a timed start request to the machine FSM.
module wm_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int START_TIMEOUT   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_sw_raw,
    input  logic       btn_next_raw,
    input  logic       btn_start_raw,
    input  logic       door_raw,
    input  logic       soap_raw,
    input  logic       busy,
    input  logic       program_done,
    output logic       power,
    output logic       doorclosed,
    output logic       soap,
    output logic [2:0] program_selection,
    output logic       start,
    output logic       done_led,
    output logic       start_fail
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(START_TIMEOUT - 1);

    localparam int N_IN    = 5;
    localparam int I_POWER = 0;
    localparam int I_NEXT  = 1;
    localparam int I_START = 2;
    localparam int I_DOOR  = 3;
    localparam int I_SOAP  = 4;

    typedef enum logic [2:0] {
        S_OFF,
        S_READY,
        S_ARMED,
        S_RUNNING,
        S_DONE
    } state_t;

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] filt;

    assign raw = {soap_raw, door_raw, btn_start_raw, btn_next_raw, power_sw_raw};

    // The filtered bit only flips after the raw value has disagreed on DEBOUNCE_CYCLES consecutive samples.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
            logic [CW-1:0] cnt_reg;
            logic          filt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else if (raw[gi] == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    filt_reg <= raw[gi];
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    logic next_d_reg;
    logic start_d_reg;
    logic door_d_reg;
    logic next_edge;
    logic start_edge;
    logic door_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_d_reg  <= 1'b0;
            start_d_reg <= 1'b0;
            door_d_reg  <= 1'b0;
        end else begin
            next_d_reg  <= filt[I_NEXT];
            start_d_reg <= filt[I_START];
            door_d_reg  <= filt[I_DOOR];
        end
    end

    assign next_edge  = filt[I_NEXT] & ~next_d_reg;
    assign start_edge = filt[I_START] & ~start_d_reg;
    assign door_fall  = door_d_reg & ~filt[I_DOOR];

    state_t     state_reg;
    logic [2:0] sel_reg;
    logic [7:0] timeout_cnt_reg;
    logic       start_reg;
    logic       done_led_reg;
    logic       start_fail_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_OFF;
            sel_reg         <= 3'd0;
            timeout_cnt_reg <= 8'd0;
            start_reg       <= 1'b0;
            done_led_reg    <= 1'b0;
            start_fail_reg  <= 1'b0;
        end else begin
            start_fail_reg <= 1'b0;
            // Losing power overrides everything else, whatever the machine was doing.
            if (state_reg != S_OFF && !filt[I_POWER]) begin
                state_reg    <= S_OFF;
                sel_reg      <= 3'd0;
                start_reg    <= 1'b0;
                done_led_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_OFF: begin
                        sel_reg      <= 3'd0;
                        start_reg    <= 1'b0;
                        done_led_reg <= 1'b0;
                        if (filt[I_POWER]) begin
                            state_reg <= S_READY;
                        end
                    end
                    S_READY: begin
                        if (start_edge && filt[I_DOOR]) begin
                            state_reg       <= S_ARMED;
                            start_reg       <= 1'b1;
                            timeout_cnt_reg <= 8'd0;
                        end else if (next_edge) begin
                            sel_reg <= (sel_reg == 3'd4) ? 3'd0 : sel_reg + 3'd1;
                        end
                    end
                    S_ARMED: begin
                        if (busy) begin
                            state_reg <= S_RUNNING;
                            start_reg <= 1'b0;
                        end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                            state_reg      <= S_READY;
                            start_reg      <= 1'b0;
                            start_fail_reg <= 1'b1;
                        end else begin
                            timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                        end
                    end
                    S_RUNNING: begin
                        if (program_done) begin
                            state_reg    <= S_DONE;
                            done_led_reg <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (door_fall || next_edge) begin
                            state_reg    <= S_READY;
                            done_led_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= S_OFF;
                    end
                endcase
            end
        end
    end

    assign power             = filt[I_POWER];
    assign doorclosed        = filt[I_DOOR];
    assign soap              = filt[I_SOAP];
    assign program_selection = sel_reg;
    assign start             = start_reg;
    assign done_led          = done_led_reg;
    assign start_fail        = start_fail_reg;

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Bench for wm_panel_ctrl: directed vector table, reset sequences, then random
// stimulus compared cycle by cycle against a behavioural model.
module tb_wm_panel_ctrl;
    localparam int DC = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power_sw_raw = 1'b0;
    logic       btn_next_raw = 1'b0;
    logic       btn_start_raw = 1'b0;
    logic       door_raw = 1'b0;
    logic       soap_raw = 1'b0;
    logic       busy = 1'b0;
    logic       program_done = 1'b0;
    logic       power;
    logic       doorclosed;
    logic       soap;
    logic [2:0] program_selection;
    logic       start;
    logic       done_led;
    logic       start_fail;

    wm_panel_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .START_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .power_sw_raw(power_sw_raw),
        .btn_next_raw(btn_next_raw),
        .btn_start_raw(btn_start_raw),
        .door_raw(door_raw),
        .soap_raw(soap_raw),
        .busy(busy),
        .program_done(program_done),
        .power(power),
        .doorclosed(doorclosed),
        .soap(soap),
        .program_selection(program_selection),
        .start(start),
        .done_led(done_led),
        .start_fail(start_fail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // Behavioural model: index 0 power, 1 next, 2 start, 3 door, 4 soap.
    localparam int M_OFF = 0, M_READY = 1, M_ARMED = 2, M_RUN = 3, M_DONE = 4;
    int m_filt[5];
    int m_run[5];
    int m_prev_next, m_prev_start, m_prev_door;
    int m_mode, m_sel, m_start, m_led, m_fail, m_armed;

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) begin
            m_filt[i] = 0;
            m_run[i]  = 0;
        end
        m_prev_next = 0; m_prev_start = 0; m_prev_door = 0;
        m_mode = M_OFF; m_sel = 0; m_start = 0; m_led = 0; m_fail = 0; m_armed = 0;
    endfunction

    function automatic void model_step();
        int raw[5];
        bit nx, st, dfall;
        raw[0] = int'(power_sw_raw); raw[1] = int'(btn_next_raw); raw[2] = int'(btn_start_raw);
        raw[3] = int'(door_raw);     raw[4] = int'(soap_raw);
        nx    = (m_filt[1] == 1) && (m_prev_next == 0);
        st    = (m_filt[2] == 1) && (m_prev_start == 0);
        dfall = (m_prev_door == 1) && (m_filt[3] == 0);
        m_fail = 0;
        if (m_mode != M_OFF && m_filt[0] == 0) begin
            m_mode = M_OFF; m_sel = 0; m_start = 0; m_led = 0;
        end else begin
            case (m_mode)
                M_OFF: begin
                    m_sel = 0; m_start = 0; m_led = 0;
                    if (m_filt[0] == 1) m_mode = M_READY;
                end
                M_READY: begin
                    if (st && m_filt[3] == 1) begin
                        m_mode = M_ARMED; m_start = 1; m_armed = 1;
                    end else if (nx) begin
                        m_sel = (m_sel + 1) % 5;
                    end
                end
                M_ARMED: begin
                    if (busy) begin
                        m_mode = M_RUN; m_start = 0;
                    end else if (m_armed == TO) begin
                        m_mode = M_READY; m_start = 0; m_fail = 1;
                    end else begin
                        m_armed++;
                    end
                end
                M_RUN: begin
                    if (program_done) begin
                        m_mode = M_DONE; m_led = 1;
                    end
                end
                default: begin
                    if (dfall || nx) begin
                        m_mode = M_READY; m_led = 0;
                    end
                end
            endcase
        end
        m_prev_next = m_filt[1]; m_prev_start = m_filt[2]; m_prev_door = m_filt[3];
        for (int i = 0; i < 5; i++) begin
            if (raw[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    m_filt[i] = raw[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endfunction

    function automatic logic [8:0] model_outs();
        return {m_filt[0][0], m_filt[3][0], m_filt[4][0], 3'(m_sel), m_start[0], m_led[0], m_fail[0]};
    endfunction

    function automatic logic [8:0] dut_outs();
        return {power, doorclosed, soap, program_selection, start, done_led, start_fail};
    endfunction

    task automatic check_outs(input string name, input logic [8:0] exp);
        checks++;
        if (dut_outs() !== exp) begin
            errors++;
            $display("FAIL %s: got pwr/door/soap/sel/start/led/fail=%b expected %b at %0t",
                     name, dut_outs(), exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        if (model_on) check_outs("model", model_outs());
    endtask

    // Input order: power, next, start, door, soap, busy, program_done.
    task automatic hold(input logic [6:0] in, input int cycles);
        {power_sw_raw, btn_next_raw, btn_start_raw, door_raw, soap_raw, busy, program_done} = in;
        repeat (cycles) tick();
    endtask

    typedef struct {
        logic [6:0] in;
        int         cycles;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] in, input int cycles, input logic pw,
                                input logic dr, input logic sp, input logic [2:0] sel,
                                input logic st, input logic led, input logic fl);
        vec_t v;
        v.in = in; v.cycles = cycles; v.exp = {pw, dr, sp, sel, st, led, fl};
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        // Power-up, debounce glitch rejection and selection stepping.
        vecs.push_back(mk(7'b0000000, 2, 0, 0, 0, 3'd0, 0, 0, 0));
        vecs.push_back(mk(7'b1000000, 3, 0, 0, 0, 3'd0, 0, 0, 0));
        vecs.push_back(mk(7'b1000000, 1, 1, 0, 0, 3'd0, 0, 0, 0));
        vecs.push_back(mk(7'b1001100, 4, 1, 1, 1, 3'd0, 0, 0, 0));
        vecs.push_back(mk(7'b1101100, 3, 1, 1, 1, 3'd0, 0, 0, 0));
        vecs.push_back(mk(7'b1001100, 2, 1, 1, 1, 3'd0, 0, 0, 0));
        vecs.push_back(mk(7'b1101100, 4, 1, 1, 1, 3'd0, 0, 0, 0));
        vecs.push_back(mk(7'b1101100, 1, 1, 1, 1, 3'd1, 0, 0, 0));
        vecs.push_back(mk(7'b1001100, 4, 1, 1, 1, 3'd1, 0, 0, 0));
        for (int k = 0; k < 7; k++) begin
            vecs.push_back(mk(7'b1101100, 5, 1, 1, 1, 3'((k + 2) % 5), 0, 0, 0));
            vecs.push_back(mk(7'b1001100, 4, 1, 1, 1, 3'((k + 2) % 5), 0, 0, 0));
        end
        // Normal start, running lockout, done and door-open exit.
        vecs.push_back(mk(7'b1011100, 4, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1011100, 1, 1, 1, 1, 3'd3, 1, 0, 0));
        vecs.push_back(mk(7'b1011100, 2, 1, 1, 1, 3'd3, 1, 0, 0));
        vecs.push_back(mk(7'b1011110, 1, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1001110, 4, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1101110, 5, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1001110, 4, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1001111, 1, 1, 1, 1, 3'd3, 0, 1, 0));
        vecs.push_back(mk(7'b1001100, 2, 1, 1, 1, 3'd3, 0, 1, 0));
        vecs.push_back(mk(7'b1000100, 3, 1, 1, 1, 3'd3, 0, 1, 0));
        vecs.push_back(mk(7'b1000100, 1, 1, 0, 1, 3'd3, 0, 1, 0));
        vecs.push_back(mk(7'b1000100, 1, 1, 0, 1, 3'd3, 0, 0, 0));
        // Start timeout: start high for exactly TO cycles, then a single fail pulse.
        vecs.push_back(mk(7'b1001100, 4, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1011100, 4, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1011100, 1, 1, 1, 1, 3'd3, 1, 0, 0));
        vecs.push_back(mk(7'b1011100, TO - 1, 1, 1, 1, 3'd3, 1, 0, 0));
        vecs.push_back(mk(7'b1011100, 1, 1, 1, 1, 3'd3, 0, 0, 1));
        vecs.push_back(mk(7'b1011100, 1, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1011100, 3, 1, 1, 1, 3'd3, 0, 0, 0));
        // Start with the door open is ignored.
        vecs.push_back(mk(7'b1000100, 4, 1, 0, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1010100, 5, 1, 0, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1010100, 3, 1, 0, 1, 3'd3, 0, 0, 0));
        // Power loss from DONE clears everything.
        vecs.push_back(mk(7'b1001100, 4, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1011100, 5, 1, 1, 1, 3'd3, 1, 0, 0));
        vecs.push_back(mk(7'b1011110, 1, 1, 1, 1, 3'd3, 0, 0, 0));
        vecs.push_back(mk(7'b1001111, 1, 1, 1, 1, 3'd3, 0, 1, 0));
        vecs.push_back(mk(7'b0001100, 3, 1, 1, 1, 3'd3, 0, 1, 0));
        vecs.push_back(mk(7'b0001100, 1, 0, 1, 1, 3'd3, 0, 1, 0));
        vecs.push_back(mk(7'b0001100, 1, 0, 1, 1, 3'd0, 0, 0, 0));

        model_reset();
        #1;
        check_outs("reset_state", 9'd0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            hold(vecs[i].in, vecs[i].cycles);
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset while ARMED clears outputs without waiting for a clock edge.
        hold(7'b1001100, 5);
        hold(7'b1011100, 5);
        check_outs("armed_before_reset", {1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0});
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("reset_async", 9'd0);
        hold(7'b0000000, 2);
        rst_n = 1'b1;
        hold(7'b0000000, 6);
        check_outs("after_reset_idle", 9'd0);

        // Raw inputs held high through reset re-filter after DC edges.
        rst_n = 1'b0;
        model_reset();
        hold(7'b1001000, 2);
        rst_n = 1'b1;
        hold(7'b1001000, DC - 1);
        check_outs("refilter_early", 9'd0);
        hold(7'b1001000, 1);
        check_outs("refilter_done", {1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});

        // Random phase compared every cycle against the model.
        model_on = 1'b1;
        power_sw_raw = 1'b1;
        door_raw = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (power_sw_raw ? ($urandom_range(299) == 0) : ($urandom_range(39) == 0))
                power_sw_raw = ~power_sw_raw;
            if ($urandom_range(7) == 0) btn_next_raw = ~btn_next_raw;
            if ($urandom_range(9) == 0) btn_start_raw = ~btn_start_raw;
            if ($urandom_range(29) == 0) door_raw = ~door_raw;
            if ($urandom_range(19) == 0) soap_raw = ~soap_raw;
            if ($urandom_range(5) == 0) busy = ~busy;
            program_done = ($urandom_range(9) == 0);
            if ($urandom_range(999) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
